paddle_tracker: RTL and testbench
=================================

// Module: paddle_tracker
// PURPOSE
// - Per-frame tracker for the player object (paddle/hand) in the camera stream. Produces the
//   collision_detected and estimated_speed inputs of the ball game controller.
// - Sits between the colour-mask stage (per-pixel hit bit) and the game controller.
// - Accumulates the object bounding box during each frame and measures centre motion frame to frame.
// - At frame end, tests bounding-box overlap against the current ball box.
// PARAMETERS
// - BALL_SIZE        20    ball edge length in ball coordinate space (pixels)
// - MIN_PIXELS       64    minimum mask-pixel count for a frame's object to be valid
// - COOLDOWN_FRAMES  4     frame ends after a hit during which no new hit is reported
// - SPEED_FILTER     0     0: raw speed; 1: estimated_speed = (prev + raw) >> 1
// PORTS
// - clk_25MHZ           in   1   pixel clock
// - reset               in   1   asynchronous, active-high
// - x_pixel             in   10  current pixel column, 640x480 space
// - y_pixel             in   10  current pixel row, 640x480 space
// - de                  in   1   active-video pixel qualifier
// - vsync               in   1   active-high frame sync; its rising edge ends a frame
// - mask_hit            in   1   pixel belongs to the object (qualified by de)
// - upscale             in   1   1: ball space 640x480; 0: ball space 320x240 (coords >>1)
// - ball_x              in   10  ball left edge, ball space
// - ball_y              in   10  ball top edge, ball space
// - collision_detected  out  1   one-cycle hit pulse
// - estimated_speed     out  10  object speed, pixels/frame (Manhattan), saturating
// - obj_valid           out  1   last completed frame held a valid object
// - obj_x_min/x_max     out  10  last valid bbox, ball space (x)
// - obj_y_min/y_max     out  10  last valid bbox, ball space (y)
// BEHAVIOUR
// - Reset: all outputs 0; bbox accumulators cleared; cooldown counter 0; prev-centre-valid 0.
//   State goes to WAIT_FRAME.
// - vsync edge detect: vsync_q registered. frame_end = vsync & ~vsync_q.
// - FSM: WAIT_FRAME -> ACCUM on frame_end. The partial frame after reset is discarded.
// - ACCUM -> LATCH on frame_end. LATCH -> COMPUTE -> REPORT -> ACCUM, one cycle each.
// - ACCUM, each cycle with de & mask_hit:
//   - update x/y min/max with the scaled coordinate (upscale ? coord : coord>>1);
//   - increment the 19-bit pixel count, saturating.
//   - A pixel on the frame_end cycle is dropped.
// - LATCH:
//   - snapshot accumulators; clear them for the next frame;
//   - valid = count >= MIN_PIXELS.
//   - Pixels arriving during LATCH..REPORT are accumulated into the new frame.
// - COMPUTE:
//   - centre = (min + max) >> 1, using an 11-bit sum;
//   - raw = |cx - cx_prev| + |cy - cy_prev|, saturated to 1023;
//   - raw = 0 unless both this frame and the previous frame are valid.
// - REPORT:
//   - update estimated_speed (raw or filtered) and obj_valid; bbox outputs update only if valid;
//   - update prev centre and prev-valid.
//   - Overlap test: ball box [ball_x, ball_x+BALL_SIZE-1] x [ball_y, ball_y+BALL_SIZE-1]
//     intersects the object bbox on both axes (inclusive edges).
//   - On overlap, with valid and cooldown==0: collision_detected=1 for this cycle only;
//     cooldown = COOLDOWN_FRAMES.
//   - Otherwise, if cooldown != 0, decrement it.
// - Latency: outputs change on the 3rd clk edge after the edge where frame_end is registered.
// - collision_detected is never high on two consecutive cycles.
// - ball_x/ball_y/upscale are sampled in REPORT and COMPUTE respectively.
//   A change to upscale mid-frame affects only the next frame's scaling.
// - Invalid frame: obj_valid=0; estimated_speed updated (0 when raw=0 path, filtered when
//   SPEED_FILTER=1); no hit. The cooldown still decrements.
// - A frame_end arriving while not in ACCUM (frames < 4 cycles apart) is ignored.
// - Reset mid-operation: immediate return to reset values; resume at the next frame_end.
// STRUCTURE
// - Shared package game_pkg:
//   - SCREEN_W=640, SCREEN_H=480, SCREEN_W_LO=320, SCREEN_H_LO=240, BALL_SIZE_DEF=20;
//   - typedef tracker_state_t {WAIT_FRAME, ACCUM, LATCH, COMPUTE, REPORT}.
// - Sub-module bbox_accumulator: min/max/count registers with clear and hit inputs.
// - Top level holds the FSM, centre/speed arithmetic, overlap test and cooldown counter.
// TESTING
// 1. Reset, mask_hit=1, de=1, no vsync for 10k cycles
//    -> all outputs 0, no collision pulse.
// 2. upscale=1, mask rect x 300..339, y 60..99 (1600 px), ball (290,80), frame_end
//    -> obj_valid=1, bbox 300/339/60/99, collision_detected pulses exactly 1 cycle at edge +3.
// 3. Same overlap held for 6 frames, COOLDOWN_FRAMES=4
//    -> pulses on frames 1 and 6 only.
// 4. SPEED_FILTER=0, rect moves +12 x and +5 y per frame
//    -> estimated_speed 0 after frame 1, 17 after frame 2.
//    - Move +800 equivalent is not possible; instead jump 0->639 and 0->479 to check saturation
//      -> 1023 clamp.
// 5. upscale=0, mask rect x 300..339, y 60..99, ball (155,40)
//    -> bbox 150/169/30/49, collision pulse.
//    - Same test with ball (175,40) -> no pulse.
// 6. 50-pixel blob
//    -> obj_valid=0, no pulse, speed 0.
//    - Then assert reset mid-frame -> outputs 0.
//    - The first partial frame after reset is discarded; the next full frame reports normally.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, the tracker FSM state type and a small arithmetic helper.
package game_pkg;

    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int SCREEN_W_LO   = 320;
    localparam int SCREEN_H_LO   = 240;
    localparam int BALL_SIZE_DEF = 20;

    typedef enum logic [2:0] {
        WAIT_FRAME,
        ACCUM,
        LATCH,
        COMPUTE,
        REPORT
    } tracker_state_t;

    function automatic logic [9:0] absDiff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/bbox_accumulator.sv
// Running min/max bounding box and saturating hit count for one frame of mask pixels.
module bbox_accumulator (
    input  logic        clk_25MHZ,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_hit,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    output logic [9:0]  o_xMin,
    output logic [9:0]  o_xMax,
    output logic [9:0]  o_yMin,
    output logic [9:0]  o_yMax,
    output logic [18:0] o_count
);

    // A clear that coincides with a hit seeds the new frame with that pixel.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            o_xMin  <= 10'h3FF;
            o_xMax  <= 10'd0;
            o_yMin  <= 10'h3FF;
            o_yMax  <= 10'd0;
            o_count <= 19'd0;
        end else if (i_clear) begin
            if (i_hit) begin
                o_xMin  <= i_x;
                o_xMax  <= i_x;
                o_yMin  <= i_y;
                o_yMax  <= i_y;
                o_count <= 19'd1;
            end else begin
                o_xMin  <= 10'h3FF;
                o_xMax  <= 10'd0;
                o_yMin  <= 10'h3FF;
                o_yMax  <= 10'd0;
                o_count <= 19'd0;
            end
        end else if (i_hit) begin
            if (i_x < o_xMin) o_xMin <= i_x;
            if (i_x > o_xMax) o_xMax <= i_x;
            if (i_y < o_yMin) o_yMin <= i_y;
            if (i_y > o_yMax) o_yMax <= i_y;
            if (o_count != 19'h7FFFF) o_count <= o_count + 19'd1;
        end
    end

endmodule

// File: rtl/paddle_tracker.sv
// Per-frame player-object tracker: bounding box, frame-to-frame centre speed and a
// cooled-down ball overlap pulse for the game controller.
module paddle_tracker
    import game_pkg::*;
#(
    parameter int BALL_SIZE       = BALL_SIZE_DEF,
    parameter int MIN_PIXELS      = 64,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int SPEED_FILTER    = 0
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic [9:0] x_pixel,
    input  logic [9:0] y_pixel,
    input  logic       de,
    input  logic       vsync,
    input  logic       mask_hit,
    input  logic       upscale,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       collision_detected,
    output logic [9:0] estimated_speed,
    output logic       obj_valid,
    output logic [9:0] obj_x_min,
    output logic [9:0] obj_x_max,
    output logic [9:0] obj_y_min,
    output logic [9:0] obj_y_max
);

    localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    tracker_state_t  r_state, w_nextState;
    logic            r_vsyncQ, w_frameEnd, r_scaleUp;
    logic            w_accHit, w_accClear;
    logic [9:0]      w_xScaled, w_yScaled;
    logic [9:0]      w_accXMin, w_accXMax, w_accYMin, w_accYMax;
    logic [18:0]     w_accCount;
    logic [9:0]      r_snapXMin, r_snapXMax, r_snapYMin, r_snapYMax;
    logic            r_snapValid;
    logic [9:0]      w_cx, w_cy, r_cx, r_cy, r_prevCx, r_prevCy;
    logic            r_prevValid;
    logic [10:0]     w_rawSum;
    logic [9:0]      w_rawSat, r_rawSpeed, w_newSpeed;
    logic [10:0]     w_ballXEnd, w_ballYEnd;
    logic            w_overlap;
    logic [CD_W-1:0] r_cooldown;

    assign w_frameEnd = vsync & ~r_vsyncQ;
    assign w_xScaled  = r_scaleUp ? x_pixel : {1'b0, x_pixel[9:1]};
    assign w_yScaled  = r_scaleUp ? y_pixel : {1'b0, y_pixel[9:1]};
    // Pixels after LATCH already belong to the next frame; the frame_end pixel is dropped.
    assign w_accHit   = de & mask_hit & (r_state != WAIT_FRAME) &
                        ~((r_state == ACCUM) & w_frameEnd);
    assign w_accClear = (r_state == LATCH);

    bbox_accumulator u_bbox (
        .clk_25MHZ (clk_25MHZ),
        .reset     (reset),
        .i_clear   (w_accClear),
        .i_hit     (w_accHit),
        .i_x       (w_xScaled),
        .i_y       (w_yScaled),
        .o_xMin    (w_accXMin),
        .o_xMax    (w_accXMax),
        .o_yMin    (w_accYMin),
        .o_yMax    (w_accYMax),
        .o_count   (w_accCount)
    );

    assign w_cx       = 10'(({1'b0, r_snapXMin} + {1'b0, r_snapXMax}) >> 1);
    assign w_cy       = 10'(({1'b0, r_snapYMin} + {1'b0, r_snapYMax}) >> 1);
    assign w_rawSum   = {1'b0, absDiff(w_cx, r_prevCx)} + {1'b0, absDiff(w_cy, r_prevCy)};
    assign w_rawSat   = w_rawSum[10] ? 10'h3FF : w_rawSum[9:0];
    assign w_newSpeed = (SPEED_FILTER != 0)
                        ? 10'(({1'b0, estimated_speed} + {1'b0, r_rawSpeed}) >> 1)
                        : r_rawSpeed;

    assign w_ballXEnd = {1'b0, ball_x} + 11'(BALL_SIZE - 1);
    assign w_ballYEnd = {1'b0, ball_y} + 11'(BALL_SIZE - 1);
    assign w_overlap  = ({1'b0, ball_x} <= {1'b0, r_snapXMax}) && (w_ballXEnd >= {1'b0, r_snapXMin}) &&
                        ({1'b0, ball_y} <= {1'b0, r_snapYMax}) && (w_ballYEnd >= {1'b0, r_snapYMin});

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) r_state <= WAIT_FRAME;
        else       r_state <= w_nextState;
    end

    // A frame_end outside ACCUM/WAIT_FRAME is simply not acted upon.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            WAIT_FRAME: if (w_frameEnd) w_nextState = ACCUM;
            ACCUM:      if (w_frameEnd) w_nextState = LATCH;
            LATCH:      w_nextState = COMPUTE;
            COMPUTE:    w_nextState = REPORT;
            REPORT:     w_nextState = ACCUM;
            default:    w_nextState = WAIT_FRAME;
        endcase
    end

    // Scale follows upscale while idle so the first frame after reset uses the live setting.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            r_vsyncQ    <= 1'b0;
            r_scaleUp   <= 1'b0;
            r_snapXMin  <= 10'd0;
            r_snapXMax  <= 10'd0;
            r_snapYMin  <= 10'd0;
            r_snapYMax  <= 10'd0;
            r_snapValid <= 1'b0;
            r_cx        <= 10'd0;
            r_cy        <= 10'd0;
            r_rawSpeed  <= 10'd0;
        end else begin
            r_vsyncQ <= vsync;
            if (r_state == WAIT_FRAME || r_state == COMPUTE) r_scaleUp <= upscale;
            if (r_state == LATCH) begin
                r_snapXMin  <= w_accXMin;
                r_snapXMax  <= w_accXMax;
                r_snapYMin  <= w_accYMin;
                r_snapYMax  <= w_accYMax;
                r_snapValid <= (w_accCount >= 19'(MIN_PIXELS));
            end
            if (r_state == COMPUTE) begin
                r_cx       <= w_cx;
                r_cy       <= w_cy;
                r_rawSpeed <= (r_snapValid && r_prevValid) ? w_rawSat : 10'd0;
            end
        end
    end

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            collision_detected <= 1'b0;
            estimated_speed    <= 10'd0;
            obj_valid          <= 1'b0;
            obj_x_min          <= 10'd0;
            obj_x_max          <= 10'd0;
            obj_y_min          <= 10'd0;
            obj_y_max          <= 10'd0;
            r_prevCx           <= 10'd0;
            r_prevCy           <= 10'd0;
            r_prevValid        <= 1'b0;
            r_cooldown         <= '0;
        end else begin
            collision_detected <= 1'b0;
            if (r_state == REPORT) begin
                estimated_speed <= w_newSpeed;
                obj_valid       <= r_snapValid;
                if (r_snapValid) begin
                    obj_x_min <= r_snapXMin;
                    obj_x_max <= r_snapXMax;
                    obj_y_min <= r_snapYMin;
                    obj_y_max <= r_snapYMax;
                end
                r_prevCx    <= r_cx;
                r_prevCy    <= r_cy;
                r_prevValid <= r_snapValid;
                if (w_overlap && r_snapValid && r_cooldown == '0) begin
                    collision_detected <= 1'b1;
                    r_cooldown         <= CD_W'(COOLDOWN_FRAMES);
                end else if (r_cooldown != '0) begin
                    r_cooldown <= r_cooldown - CD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed self-checking bench for paddle_tracker: frames are abbreviated to the mask
// rectangle only, followed by a vsync pulse.
module tb_paddle_tracker;

    logic       clk_25MHZ = 1'b0;
    logic       reset;
    logic [9:0] x_pixel, y_pixel;
    logic       de, vsync, mask_hit, upscale;
    logic [9:0] ball_x, ball_y;
    logic       collision_detected;
    logic [9:0] estimated_speed;
    logic       obj_valid;
    logic [9:0] obj_x_min, obj_x_max, obj_y_min, obj_y_max;

    int totalChecks = 0;
    int badChecks   = 0;
    int pulseCount  = 0;
    int consecCount = 0;
    logic prevCol   = 1'b0;

    paddle_tracker dut (
        .clk_25MHZ          (clk_25MHZ),
        .reset              (reset),
        .x_pixel            (x_pixel),
        .y_pixel            (y_pixel),
        .de                 (de),
        .vsync              (vsync),
        .mask_hit           (mask_hit),
        .upscale            (upscale),
        .ball_x             (ball_x),
        .ball_y             (ball_y),
        .collision_detected (collision_detected),
        .estimated_speed    (estimated_speed),
        .obj_valid          (obj_valid),
        .obj_x_min          (obj_x_min),
        .obj_x_max          (obj_x_max),
        .obj_y_min          (obj_y_min),
        .obj_y_max          (obj_y_max)
    );

    always #20 clk_25MHZ = ~clk_25MHZ;

    // Count every collision pulse and any back-to-back high cycles.
    always @(negedge clk_25MHZ) begin
        if (collision_detected) pulseCount++;
        if (collision_detected && prevCol) consecCount++;
        prevCol = collision_detected;
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one frame: rectangle of mask pixels (empty when x1<x0), then a vsync rising edge.
    // trace[k-1] holds collision_detected sampled just after the k-th edge past frame_end.
    task automatic applyStimulus(input int x0, input int x1, input int y0, input int y1,
                                 output logic [4:0] trace);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                x_pixel = 10'(x); y_pixel = 10'(y); de = 1'b1; mask_hit = 1'b1;
                @(negedge clk_25MHZ);
            end
        end
        de = 1'b0; mask_hit = 1'b0;
        vsync = 1'b1;
        @(posedge clk_25MHZ);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk_25MHZ);
            #1;
            trace[k-1] = collision_detected;
            if (k == 2) vsync = 1'b0;
        end
        @(negedge clk_25MHZ);
    endtask

    task automatic checkBox(input string tag, input int xmin, input int xmax,
                            input int ymin, input int ymax);
        checkOutput({tag, ".xmin"}, obj_x_min, xmin);
        checkOutput({tag, ".xmax"}, obj_x_max, xmax);
        checkOutput({tag, ".ymin"}, obj_y_min, ymin);
        checkOutput({tag, ".ymax"}, obj_y_max, ymax);
    endtask

    initial begin
        logic [4:0] tr;
        int p0;

        reset = 1'b1; x_pixel = 10'd123; y_pixel = 10'd45; de = 1'b0; vsync = 1'b0;
        mask_hit = 1'b0; upscale = 1'b1; ball_x = 10'd290; ball_y = 10'd80;
        repeat (3) @(negedge clk_25MHZ);
        checkOutput("rst.valid", obj_valid, 0);
        checkOutput("rst.speed", estimated_speed, 0);
        checkOutput("rst.col", collision_detected, 0);
        checkBox("rst", 0, 0, 0, 0);

        // Test 1: hits but no vsync for 10k cycles
        p0 = pulseCount;
        reset = 1'b0; de = 1'b1; mask_hit = 1'b1;
        repeat (10000) @(negedge clk_25MHZ);
        checkOutput("t1.valid", obj_valid, 0);
        checkOutput("t1.speed", estimated_speed, 0);
        checkBox("t1", 0, 0, 0, 0);
        checkOutput("t1.pulses", pulseCount - p0, 0);
        de = 1'b0; mask_hit = 1'b0;

        applyStimulus(1, 0, 1, 0, tr);
        checkOutput("first.trace", tr, 0);
        checkOutput("first.valid", obj_valid, 0);

        // Tests 2 and 3: overlap held for 6 frames
        p0 = pulseCount;
        for (int f = 1; f <= 6; f++) begin
            applyStimulus(300, 339, 60, 99, tr);
            checkOutput($sformatf("t3.f%0d.trace", f), tr, (f == 1 || f == 6) ? 5'b00100 : 5'b00000);
            checkOutput($sformatf("t3.f%0d.valid", f), obj_valid, 1);
            checkOutput($sformatf("t3.f%0d.speed", f), estimated_speed, 0);
        end
        checkBox("t2", 300, 339, 60, 99);
        checkOutput("t3.pulses", pulseCount - p0, 2);

        // Test 4: speed
        ball_x = 10'd0; ball_y = 10'd300;
        applyStimulus(1, 0, 1, 0, tr);
        checkOutput("t4.empty.valid", obj_valid, 0);
        checkOutput("t4.empty.speed", estimated_speed, 0);
        checkBox("t4.hold", 300, 339, 60, 99);
        applyStimulus(100, 139, 100, 139, tr);
        checkOutput("t4.f1.speed", estimated_speed, 0);
        applyStimulus(112, 151, 105, 144, tr);
        checkOutput("t4.f2.speed", estimated_speed, 17);
        applyStimulus(0, 7, 0, 7, tr);
        checkOutput("t4.corner.speed", estimated_speed, 249);
        applyStimulus(632, 639, 472, 479, tr);
        checkOutput("t4.sat.speed", estimated_speed, 1023);
        checkBox("t4.sat", 632, 639, 472, 479);
        checkOutput("t4.trace", tr, 0);

        // Test 5: half-resolution ball space
        upscale = 1'b0; ball_x = 10'd155; ball_y = 10'd40;
        applyStimulus(1, 0, 1, 0, tr);
        applyStimulus(300, 339, 60, 99, tr);
        checkBox("t5", 150, 169, 30, 49);
        checkOutput("t5.valid", obj_valid, 1);
        checkOutput("t5.trace", tr, 5'b00100);
        for (int f = 0; f < 4; f++) applyStimulus(1, 0, 1, 0, tr);
        ball_x = 10'd175;
        applyStimulus(300, 339, 60, 99, tr);
        checkOutput("t5b.trace", tr, 0);
        checkOutput("t5b.valid", obj_valid, 1);
        checkBox("t5b", 150, 169, 30, 49);

        // Test 6: small blob, then reset mid-frame
        upscale = 1'b1; ball_x = 10'd200; ball_y = 10'd200;
        applyStimulus(1, 0, 1, 0, tr);
        applyStimulus(200, 209, 200, 204, tr);
        checkOutput("t6.valid", obj_valid, 0);
        checkOutput("t6.speed", estimated_speed, 0);
        checkOutput("t6.trace", tr, 0);
        checkOutput("t6.hold", obj_x_min, 150);
        for (int x = 10; x < 30; x++) begin
            x_pixel = 10'(x); y_pixel = 10'd20; de = 1'b1; mask_hit = 1'b1;
            @(negedge clk_25MHZ);
        end
        reset = 1'b1;
        @(negedge clk_25MHZ);
        checkOutput("t6.rst.valid", obj_valid, 0);
        checkOutput("t6.rst.speed", estimated_speed, 0);
        checkBox("t6.rst", 0, 0, 0, 0);
        reset = 1'b0; ball_x = 10'd0; ball_y = 10'd0;
        applyStimulus(300, 339, 60, 99, tr);
        checkOutput("t6.partial.valid", obj_valid, 0);
        checkOutput("t6.partial.xmax", obj_x_max, 0);
        applyStimulus(400, 439, 200, 239, tr);
        checkOutput("t6.full.valid", obj_valid, 1);
        checkBox("t6.full", 400, 439, 200, 239);
        checkOutput("t6.full.speed", estimated_speed, 0);
        checkOutput("t6.full.trace", tr, 0);

        checkOutput("consecutive", consecCount, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
